// File: rtl/csr_ctrl.sv
// csr_ctrl: sequences one CSR or trap operation at a time against the CSR
// register file (read, then write), then returns the old value or a PC
// redirect to the pipeline over a valid/ready response channel.
module csr_ctrl #(
  parameter int                 DATA_W      = 32,
  parameter int                 ADDR_W      = 12,
  parameter logic [DATA_W-1:0]  ECALL_CAUSE = DATA_W'(11)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_src,
  input  logic              req_src_zero,
  input  logic [DATA_W-1:0] req_pc,
  output logic [ADDR_W-1:0] csr_raddr,
  input  logic [DATA_W-1:0] csr_rdata,
  output logic [ADDR_W-1:0] csr_waddr1,
  output logic [DATA_W-1:0] csr_wdata1,
  output logic              csr_wen1,
  output logic [ADDR_W-1:0] csr_waddr2,
  output logic [DATA_W-1:0] csr_wdata2,
  output logic              csr_wen2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_redirect,
  output logic [DATA_W-1:0] rsp_target,
  output logic              rsp_illegal
);

  localparam logic [2:0] OP_CSRRW = 3'd0;
  localparam logic [2:0] OP_CSRRS = 3'd1;
  localparam logic [2:0] OP_CSRRC = 3'd2;
  localparam logic [2:0] OP_ECALL = 3'd3;
  localparam logic [2:0] OP_MRET  = 3'd4;

  localparam logic [ADDR_W-1:0] ADDR_MSTATUS = ADDR_W'(12'h300);
  localparam logic [ADDR_W-1:0] ADDR_MTVEC   = ADDR_W'(12'h305);
  localparam logic [ADDR_W-1:0] ADDR_MEPC    = ADDR_W'(12'h341);
  localparam logic [ADDR_W-1:0] ADDR_MCAUSE  = ADDR_W'(12'h342);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  src_q, src_d;
  logic               src_zero_q, src_zero_d;
  logic [DATA_W-1:0]  pc_q, pc_d;
  logic [DATA_W-1:0]  old_q, old_d;

  logic is_csr_op;
  logic addr_ok;
  logic illegal;

  // Classify the latched request; ECALL/MRET use fixed addresses so only CSR ops are address-checked
  always_comb begin
    is_csr_op = (op_q == OP_CSRRW) || (op_q == OP_CSRRS) || (op_q == OP_CSRRC);
    addr_ok   = (addr_q == ADDR_MSTATUS) || (addr_q == ADDR_MTVEC) ||
                (addr_q == ADDR_MEPC) || (addr_q == ADDR_MCAUSE);
    illegal   = (op_q > OP_MRET) || (is_csr_op && !addr_ok);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: fixed READ -> WRITE -> RESP sequence, RESP waits for the consumer
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (req_valid) state_d = S_READ;
      S_READ:  state_d = S_WRITE;
      S_WRITE: state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch on accept, old-value capture during READ
  always_comb begin
    op_d       = op_q;
    addr_d     = addr_q;
    src_d      = src_q;
    src_zero_d = src_zero_q;
    pc_d       = pc_q;
    old_d      = old_q;
    if (state_q == S_IDLE && req_valid) begin
      op_d       = req_op;
      addr_d     = req_addr;
      src_d      = req_src;
      src_zero_d = req_src_zero;
      pc_d       = req_pc;
    end
    if (state_q == S_READ) old_d = csr_rdata;
  end

  // Datapath registers; reset clears everything so an aborted operation leaves no trace
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      addr_q     <= '0;
      src_q      <= '0;
      src_zero_q <= 1'b0;
      pc_q       <= '0;
      old_q      <= '0;
    end else begin
      op_q       <= op_d;
      addr_q     <= addr_d;
      src_q      <= src_d;
      src_zero_q <= src_zero_d;
      pc_q       <= pc_d;
      old_q      <= old_d;
    end
  end

  // Outputs decoded from state; everything idles at zero outside its own state
  always_comb begin
    req_ready    = (state_q == S_IDLE) && rst_n;
    csr_raddr    = '0;
    csr_waddr1   = '0;
    csr_wdata1   = '0;
    csr_wen1     = 1'b0;
    csr_waddr2   = '0;
    csr_wdata2   = '0;
    csr_wen2     = 1'b0;
    rsp_valid    = 1'b0;
    rsp_rdata    = '0;
    rsp_redirect = 1'b0;
    rsp_target   = '0;
    rsp_illegal  = 1'b0;
    unique case (state_q)
      S_READ: begin
        if (op_q == OP_ECALL)     csr_raddr = ADDR_MTVEC;
        else if (op_q == OP_MRET) csr_raddr = ADDR_MEPC;
        else                      csr_raddr = addr_q;
      end
      S_WRITE: begin
        if (!illegal) begin
          unique case (op_q)
            OP_CSRRW: begin
              csr_wen1   = 1'b1;
              csr_waddr1 = addr_q;
              csr_wdata1 = src_q;
            end
            OP_CSRRS: begin
              csr_wen1   = !src_zero_q;
              csr_waddr1 = addr_q;
              csr_wdata1 = old_q | src_q;
            end
            OP_CSRRC: begin
              csr_wen1   = !src_zero_q;
              csr_waddr1 = addr_q;
              csr_wdata1 = old_q & ~src_q;
            end
            OP_ECALL: begin
              csr_wen1   = 1'b1;
              csr_waddr1 = ADDR_MEPC;
              csr_wdata1 = pc_q;
              csr_wen2   = 1'b1;
              csr_waddr2 = ADDR_MCAUSE;
              csr_wdata2 = ECALL_CAUSE;
            end
            default: ;
          endcase
        end
      end
      S_RESP: begin
        rsp_valid    = 1'b1;
        rsp_illegal  = illegal;
        rsp_rdata    = (is_csr_op && !illegal) ? old_q : '0;
        rsp_redirect = (op_q == OP_ECALL) || (op_q == OP_MRET);
        rsp_target   = rsp_redirect ? old_q : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_ctrl.sv
// tb_csr_ctrl: directed tests for csr_ctrl against a small CSR register-file model.
module tb_csr_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_src = '0;
  logic        req_src_zero = 1'b0;
  logic [31:0] req_pc = '0;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic [11:0] csr_waddr1, csr_waddr2;
  logic [31:0] csr_wdata1, csr_wdata2;
  logic        csr_wen1, csr_wen2;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_redirect;
  logic [31:0] rsp_target;
  logic        rsp_illegal;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  csr_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_src(req_src), .req_src_zero(req_src_zero), .req_pc(req_pc),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_waddr1(csr_waddr1), .csr_wdata1(csr_wdata1), .csr_wen1(csr_wen1),
    .csr_waddr2(csr_waddr2), .csr_wdata2(csr_wdata2), .csr_wen2(csr_wen2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_redirect(rsp_redirect), .rsp_target(rsp_target), .rsp_illegal(rsp_illegal)
  );

  // Register-file model: index 0 mstatus, 1 mtvec, 2 mepc, 3 mcause
  logic [31:0] rf [4];
  logic        poke_en = 1'b0;
  logic [1:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;
  int wen1_cnt = 0, wen2_cnt = 0, both_cnt = 0;
  logic [11:0] last_waddr1 = '0, last_waddr2 = '0;
  logic [31:0] last_wdata1 = '0, last_wdata2 = '0;

  function automatic int idx_of(input logic [11:0] a);
    case (a)
      12'h300: return 0;
      12'h305: return 1;
      12'h341: return 2;
      12'h342: return 3;
      default: return -1;
    endcase
  endfunction

  always_comb begin
    csr_rdata = 32'hDEADBEEF;
    if (idx_of(csr_raddr) >= 0) csr_rdata = rf[idx_of(csr_raddr)];
  end

  always @(posedge clk) begin
    if (poke_en) rf[poke_idx] <= poke_val;
    if (csr_wen1) begin
      wen1_cnt    <= wen1_cnt + 1;
      last_waddr1 <= csr_waddr1;
      last_wdata1 <= csr_wdata1;
      if (idx_of(csr_waddr1) >= 0) rf[idx_of(csr_waddr1)] <= csr_wdata1;
    end
    if (csr_wen2) begin
      wen2_cnt    <= wen2_cnt + 1;
      last_waddr2 <= csr_waddr2;
      last_wdata2 <= csr_wdata2;
      if (idx_of(csr_waddr2) >= 0) rf[idx_of(csr_waddr2)] <= csr_wdata2;
    end
    if (csr_wen1 && csr_wen2) both_cnt <= both_cnt + 1;
  end

  task automatic poke(input logic [1:0] idx, input logic [31:0] val);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = idx; poke_val = val;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Observations of the last operation
  int          obs_lat, obs_unstable, obs_w1, obs_w2, obs_both;
  logic        obs_accepted, obs_rr_busy, obs_valid_after, obs_rr_after;
  logic [31:0] obs_rdata, obs_target;
  logic        obs_redirect, obs_illegal;

  task automatic run_op(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] src,
                        input logic sz, input logic [31:0] pc, input int hold);
    int w1_0, w2_0, b0, edges;
    @(negedge clk);
    obs_accepted = req_ready;
    w1_0 = wen1_cnt; w2_0 = wen2_cnt; b0 = both_cnt;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_src = src;
    req_src_zero = sz; req_pc = pc;
    @(negedge clk);
    req_valid = 1'b0; req_op = '0; req_addr = '0; req_src = '0; req_src_zero = 1'b0; req_pc = '0;
    obs_rr_busy = 1'b0;
    edges = 0;
    while (!rsp_valid && edges < 10) begin
      if (req_ready) obs_rr_busy = 1'b1;
      @(negedge clk);
      edges++;
    end
    obs_lat = edges;
    obs_rdata = rsp_rdata; obs_redirect = rsp_redirect;
    obs_target = rsp_target; obs_illegal = rsp_illegal;
    obs_unstable = 0;
    for (int i = 0; i < hold; i++) begin
      if (req_ready) obs_rr_busy = 1'b1;
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== obs_rdata || rsp_redirect !== obs_redirect ||
          rsp_target !== obs_target || rsp_illegal !== obs_illegal) obs_unstable++;
    end
    if (req_ready) obs_rr_busy = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    obs_valid_after = rsp_valid;
    obs_rr_after = req_ready;
    obs_w1 = wen1_cnt - w1_0; obs_w2 = wen2_cnt - w2_0; obs_both = both_cnt - b0;
    $display("op=%0d addr=%h src=%h lat=%0d rdata=%h redir=%0b target=%h illegal=%0b w1=%0d w2=%0d",
             op, addr, src, obs_lat, obs_rdata, obs_redirect, obs_target, obs_illegal, obs_w1, obs_w2);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_low got=%b exp=0", req_ready); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || csr_wen1 !== 1'b0 || csr_wen2 !== 1'b0 || csr_raddr !== 12'h0) begin
      failures++;
      $display("FAIL reset_outputs got ready=%b valid=%b wen1=%b wen2=%b raddr=%h exp 1 0 0 0 000",
               req_ready, rsp_valid, csr_wen1, csr_wen2, csr_raddr);
    end
  endtask

  task automatic test_csrrw;
    run_op(3'd0, 12'h305, 32'h80000100, 1'b0, 32'h0, 0);
    checks++;
    if (obs_lat !== 2 || obs_accepted !== 1'b1) begin failures++; $display("FAIL csrrw_latency got=%0d acc=%b exp=2 acc=1", obs_lat, obs_accepted); end
    checks++;
    if (obs_w1 !== 1 || obs_w2 !== 0 || last_waddr1 !== 12'h305 || last_wdata1 !== 32'h80000100) begin
      failures++;
      $display("FAIL csrrw_write got w1=%0d w2=%0d addr=%h data=%h exp 1 0 305 80000100", obs_w1, obs_w2, last_waddr1, last_wdata1);
    end
    checks++;
    if (obs_rdata !== 32'h0 || obs_redirect !== 1'b0 || obs_illegal !== 1'b0) begin
      failures++; $display("FAIL csrrw_rsp got rdata=%h redir=%b ill=%b exp 0 0 0", obs_rdata, obs_redirect, obs_illegal);
    end
    checks++;
    if (obs_valid_after !== 1'b0 || obs_rr_after !== 1'b1 || obs_rr_busy !== 1'b0) begin
      failures++; $display("FAIL csrrw_handshake got valid=%b ready=%b busy_ready=%b exp 0 1 0", obs_valid_after, obs_rr_after, obs_rr_busy);
    end
  endtask

  task automatic test_csrrs_csrrc;
    run_op(3'd1, 12'h300, 32'h8, 1'b1, 32'h0, 0);
    checks++;
    if (obs_w1 !== 0 || obs_rdata !== 32'h1800) begin
      failures++; $display("FAIL csrrs_zero got w1=%0d rdata=%h exp 0 1800", obs_w1, obs_rdata);
    end
    run_op(3'd1, 12'h300, 32'h8, 1'b0, 32'h0, 0);
    checks++;
    if (obs_w1 !== 1 || last_waddr1 !== 12'h300 || last_wdata1 !== 32'h1808 || obs_rdata !== 32'h1800) begin
      failures++; $display("FAIL csrrs_set got w1=%0d addr=%h data=%h rdata=%h exp 1 300 1808 1800", obs_w1, last_waddr1, last_wdata1, obs_rdata);
    end
    run_op(3'd2, 12'h300, 32'h1800, 1'b0, 32'h0, 0);
    checks++;
    if (obs_w1 !== 1 || last_wdata1 !== 32'h8 || obs_rdata !== 32'h1808) begin
      failures++; $display("FAIL csrrc_clear got w1=%0d data=%h rdata=%h exp 1 8 1808", obs_w1, last_wdata1, obs_rdata);
    end
  endtask

  task automatic test_ecall;
    run_op(3'd3, 12'h000, 32'h0, 1'b0, 32'h80000040, 0);
    checks++;
    if (obs_w1 !== 1 || obs_w2 !== 1 || obs_both !== 1) begin
      failures++; $display("FAIL ecall_pulses got w1=%0d w2=%0d both=%0d exp 1 1 1", obs_w1, obs_w2, obs_both);
    end
    checks++;
    if (last_waddr1 !== 12'h341 || last_wdata1 !== 32'h80000040 || last_waddr2 !== 12'h342 || last_wdata2 !== 32'd11) begin
      failures++; $display("FAIL ecall_data got %h/%h %h/%h exp 341/80000040 342/0000000b", last_waddr1, last_wdata1, last_waddr2, last_wdata2);
    end
    checks++;
    if (obs_redirect !== 1'b1 || obs_target !== 32'h80000100 || obs_rdata !== 32'h0) begin
      failures++; $display("FAIL ecall_rsp got redir=%b target=%h rdata=%h exp 1 80000100 0", obs_redirect, obs_target, obs_rdata);
    end
  endtask

  task automatic test_mret_backpressure;
    poke(2'd2, 32'h80000044);
    run_op(3'd4, 12'h000, 32'h0, 1'b0, 32'h0, 5);
    checks++;
    if (obs_redirect !== 1'b1 || obs_target !== 32'h80000044 || obs_rdata !== 32'h0) begin
      failures++; $display("FAIL mret_rsp got redir=%b target=%h rdata=%h exp 1 80000044 0", obs_redirect, obs_target, obs_rdata);
    end
    checks++;
    if (obs_unstable !== 0 || obs_rr_busy !== 1'b0 || obs_w1 !== 0 || obs_w2 !== 0) begin
      failures++; $display("FAIL mret_hold got unstable=%0d busy_ready=%b w1=%0d w2=%0d exp 0 0 0 0", obs_unstable, obs_rr_busy, obs_w1, obs_w2);
    end
  endtask

  task automatic test_illegal;
    run_op(3'd0, 12'h7C0, 32'h55, 1'b0, 32'h0, 0);
    checks++;
    if (obs_illegal !== 1'b1 || obs_w1 !== 0 || obs_w2 !== 0 || obs_rdata !== 32'h0) begin
      failures++; $display("FAIL illegal_addr got ill=%b w1=%0d w2=%0d rdata=%h exp 1 0 0 0", obs_illegal, obs_w1, obs_w2, obs_rdata);
    end
    run_op(3'd5, 12'h300, 32'h55, 1'b0, 32'h0, 0);
    checks++;
    if (obs_illegal !== 1'b1 || obs_w1 !== 0 || obs_redirect !== 1'b0) begin
      failures++; $display("FAIL illegal_op got ill=%b w1=%0d redir=%b exp 1 0 0", obs_illegal, obs_w1, obs_redirect);
    end
  endtask

  task automatic test_reset_mid_write;
    int w1_0;
    @(negedge clk);
    w1_0 = wen1_cnt;
    req_valid = 1'b1; req_op = 3'd0; req_addr = 12'h305; req_src = 32'h12345678;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (csr_wen1 !== 1'b1) begin failures++; $display("FAIL midwrite_in_write got wen1=%b exp 1", csr_wen1); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (csr_wen1 !== 1'b0) begin failures++; $display("FAIL midwrite_abort got wen1=%b exp 0", csr_wen1); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (wen1_cnt - w1_0 !== 0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL midwrite_recover got w1=%0d ready=%b valid=%b exp 0 1 0", wen1_cnt - w1_0, req_ready, rsp_valid);
    end
    $display("reset during WRITE: w1=%0d ready=%b", wen1_cnt - w1_0, req_ready);
    run_op(3'd1, 12'h305, 32'h0, 1'b1, 32'h0, 0);
    checks++;
    if (obs_rdata !== 32'h80000100 || obs_lat !== 2) begin
      failures++; $display("FAIL midwrite_mtvec got rdata=%h lat=%0d exp 80000100 2", obs_rdata, obs_lat);
    end
  endtask

  initial begin
    rf[0] = 32'h0; rf[1] = 32'h0; rf[2] = 32'h0; rf[3] = 32'h0;
    test_reset;
    poke(2'd0, 32'h1800);
    poke(2'd1, 32'h0);
    test_csrrw;
    test_csrrs_csrrc;
    test_ecall;
    test_mret_backpressure;
    test_illegal;
    test_reset_mid_write;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
